counter_step_ctrl: RTL and testbench



---
 rtl/counter_step_ctrl_pkg.sv | 17 +
 rtl/counter_step_ctrl_if.sv | 31 +++
 rtl/counter_mod_updn.sv | 37 +++
 rtl/counter_step_ctrl.sv | 94 +++++++++
 tb/tb_counter_step_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_step_ctrl_pkg.sv
// Shared definitions for the step-command counter controller:
// FSM state encoding and default counter/command field widths.
package counter_ctrl_pkg;

    localparam int MOD_DEF = 7;
    localparam int CW_DEF  = 3;
    localparam int SW_DEF  = 4;
    localparam int GW_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_step_ctrl_if.sv
// Command handshake and counter status bundle between a host (master)
// and the step controller (slave).
interface counter_step_ctrl_if #(
    parameter int CW = 3,
    parameter int SW = 4,
    parameter int GW = 2
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_up;
    logic [SW-1:0] cmd_steps;
    logic [GW-1:0] cmd_gap;
    logic          abort;
    logic [CW-1:0] q;
    logic          cnt_en;
    logic          busy;
    logic          done;
    logic          wrap;

    modport master (
        output cmd_valid, cmd_up, cmd_steps, cmd_gap, abort,
        input  cmd_ready, q, cnt_en, busy, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_up, cmd_steps, cmd_gap, abort,
        output cmd_ready, q, cnt_en, busy, done, wrap
    );

endinterface

// File: rtl/counter_mod_updn.sv
// Modulo-MOD up/down counter with enable; wrap is a registered pulse that
// lines up with the cycle in which the wrapped value is visible on q.
module counter_mod_updn #(
    parameter int MOD = 7,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          up,
    output logic [CW-1:0] q,
    output logic          wrap
);

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur,
                                                 input logic          dir);
        if (dir)
            return (cur == CW'(MOD - 1)) ? '0 : cur + CW'(1);
        else
            return (cur == '0) ? CW'(MOD - 1) : cur - CW'(1);
    endfunction

    logic at_boundary;
    assign at_boundary = up ? (q == CW'(MOD - 1)) : (q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= en && at_boundary;
            if (en)
                q <= next_count(q, up);
        end
    end

endmodule

// File: rtl/counter_step_ctrl.sv
// Command sequencer: accepts "N steps up/down with G idle cycles between
// steps", drives the mod counter and pulses done when the command ends.
module counter_step_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int MOD = MOD_DEF,
    parameter int CW  = CW_DEF,
    parameter int SW  = SW_DEF,
    parameter int GW  = GW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    counter_step_ctrl_if.slave  bus
);

    state_t        state;
    logic          dir;
    logic [SW-1:0] rem;
    logic [GW-1:0] gap;
    logic [GW-1:0] gcnt;
    logic          step_en;
    logic [CW-1:0] q_w;
    logic          wrap_w;

    // abort suppresses the step of the very cycle it arrives in
    assign step_en = (state == STEP) && !bus.abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir   <= 1'b0;
            rem   <= '0;
            gap   <= '0;
            gcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        dir   <= bus.cmd_up;
                        rem   <= bus.cmd_steps;
                        gap   <= bus.cmd_gap;
                        state <= (bus.cmd_steps == '0) ? DONE : STEP;
                    end
                end
                STEP: begin
                    if (bus.abort) begin
                        state <= DONE;
                    end else begin
                        rem <= rem - SW'(1);
                        if (rem == SW'(1)) begin
                            state <= DONE;
                        end else if (gap == '0) begin
                            state <= STEP;
                        end else begin
                            state <= WAIT;
                            gcnt  <= gap;
                        end
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        state <= DONE;
                    end else begin
                        gcnt <= gcnt - GW'(1);
                        if (gcnt == GW'(1))
                            state <= STEP;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    counter_mod_updn #(
        .MOD (MOD),
        .CW  (CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (step_en),
        .up   (dir),
        .q    (q_w),
        .wrap (wrap_w)
    );

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.cnt_en    = step_en;
    assign bus.q         = q_w;
    assign bus.wrap      = wrap_w;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Self-checking bench: directed command table, hand-written corner
// sequences and random commands against a per-command schedule model.
module tb_counter_step_ctrl;

    localparam int MOD = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_step_ctrl_if bus ();

    counter_step_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mq       = 0;

    typedef struct {
        bit rst_first;
        bit up;
        int n;
        int gap;
        int abort_at;
        int exp_q;
        int exp_wraps;
        int exp_en;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input int busy_e, input int ready_e,
                              input int done_e, input int en_e, input int wrap_e, input int q_e);
        chk({name, " busy"},   int'(bus.busy),      busy_e);
        chk({name, " ready"},  int'(bus.cmd_ready), ready_e);
        chk({name, " done"},   int'(bus.done),      done_e);
        chk({name, " cnt_en"}, int'(bus.cnt_en),    en_e);
        chk({name, " wrap"},   int'(bus.wrap),      wrap_e);
        chk({name, " q"},      int'(bus.q),         q_e);
    endtask

    // Reset for two cycles; entered and left at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst ready_low", int'(bus.cmd_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mq  = 0;
        @(negedge clk);
        chk_status("after_rst", 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    // Issue one command and check every cycle against a schedule computed
    // from the command itself: step i sits at cycle i*(gap+1) after accept.
    task automatic run_cmd(input string name, input bit up, input int n, input int gap,
                           input int abort_at, output int n_en, output int n_wrap,
                           output int n_done);
        int s, last, done_c;
        bit wrap_e;
        n_en = 0; n_wrap = 0; n_done = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_up    = up;
        bus.cmd_steps = 4'(n);
        bus.cmd_gap   = 2'(gap);
        @(negedge clk);
        chk({name, " idle_ready"}, int'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        s    = gap + 1;
        last = (n == 0) ? -1 : (n - 1) * s;
        if (n == 0)                                done_c = 0;
        else if (abort_at >= 0 && abort_at <= last) done_c = abort_at + 1;
        else                                       done_c = last + 1;
        wrap_e = 1'b0;
        for (int c = 0; c <= done_c; c++) begin
            bit en_e;
            bus.abort = (c == abort_at);
            en_e = (c < done_c) && (c % s == 0) && (c != abort_at);
            @(negedge clk);
            chk_status(name, 1, 0, int'(c == done_c), int'(en_e), int'(wrap_e), mq);
            n_en   += int'(bus.cnt_en);
            n_wrap += int'(bus.wrap);
            n_done += int'(bus.done);
            if (en_e) begin
                wrap_e = up ? (mq == MOD - 1) : (mq == 0);
                mq     = up ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
            end else begin
                wrap_e = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.abort = 1'b0;
        @(negedge clk);
        chk_status({name, " back_idle"}, 0, 1, 0, 0, 0, mq);
        @(posedge clk); #1;
    endtask

    initial begin
        int ne, nw, nd;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_up    = 1'b0;
        bus.cmd_steps = '0;
        bus.cmd_gap   = '0;
        bus.abort     = 1'b0;

        //         rst up  n  gap abort  q  wraps en
        vt[0] = '{1, 1, 3, 0, -1, 3, 0, 3};
        vt[1] = '{1, 1, 9, 0, -1, 2, 1, 9};
        vt[2] = '{1, 0, 1, 0, -1, 6, 1, 1};
        vt[3] = '{1, 1, 2, 0, -1, 2, 0, 2};
        vt[4] = '{0, 1, 2, 2, -1, 4, 0, 2};
        vt[5] = '{1, 1, 5, 0,  2, 2, 0, 2};
        vt[6] = '{0, 1, 0, 1, -1, 2, 0, 0};
        vt[7] = '{0, 0, 3, 1, -1, 6, 1, 3};
        vt[8] = '{0, 1, 4, 1,  6, 2, 1, 3};
        vt[9] = '{0, 0, 2, 3,  2, 1, 0, 1};

        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vt[i].rst_first) do_reset();
            run_cmd(nm, vt[i].up, vt[i].n, vt[i].gap, vt[i].abort_at, ne, nw, nd);
            chk({nm, " final_q"}, int'(bus.q), vt[i].exp_q);
            chk({nm, " wraps"},   nw, vt[i].exp_wraps);
            chk({nm, " steps"},   ne, vt[i].exp_en);
            chk({nm, " dones"},   nd, 1);
        end

        // abort while idle has no effect
        bus.abort = 1'b1;
        @(negedge clk);
        chk_status("idle_abort", 0, 1, 0, 0, 0, mq);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk_status("idle_abort_after", 0, 1, 0, 0, 0, mq);
        @(posedge clk); #1;

        // host holds cmd_valid: second command only taken once back in IDLE
        bus.cmd_valid = 1'b1;
        bus.cmd_up    = 1'b1;
        bus.cmd_steps = 4'd1;
        bus.cmd_gap   = 2'd0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_status("hold_step1", 1, 0, 0, 1, 0, mq);
        @(posedge clk); #1;
        @(negedge clk);
        chk_status("hold_done1", 1, 0, 1, 0, int'(mq == MOD - 1), (mq + 1) % MOD);
        @(posedge clk); #1;
        @(negedge clk);
        chk_status("hold_idle", 0, 1, 0, 0, 0, (mq + 1) % MOD);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk_status("hold_step2", 1, 0, 0, 1, 0, (mq + 1) % MOD);
        @(posedge clk); #1;
        @(negedge clk);
        chk_status("hold_done2", 1, 0, 1, 0, int'((mq + 1) % MOD == MOD - 1), (mq + 2) % MOD);
        mq = (mq + 2) % MOD;
        @(posedge clk); #1;

        // reset in the middle of a long command
        bus.cmd_valid = 1'b1;
        bus.cmd_up    = 1'b1;
        bus.cmd_steps = 4'd9;
        bus.cmd_gap   = 2'd1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_status("midrst", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mq  = 0;
        @(negedge clk);
        chk_status("midrst_release", 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            int n, g, ab;
            bit up;
            up = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, 15);
            g  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n * (g + 1) + 1) : -1;
            run_cmd($sformatf("rnd%0d", i), up, n, g, ab, ne, nw, nd);
            chk($sformatf("rnd%0d dones", i), nd, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
